// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: bit-slip alignment on control tokens,
// then symbol decode into video byte / control bits with data enable.
module tmds_rx_decoder #(
  parameter int SEARCH_WINDOW = 64,
  parameter int LOCK_COUNT    = 8,
  parameter int LOSS_TIMEOUT  = 4095
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] rx_word,
  output logic       locked,
  output logic [3:0] offset,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl
);

  localparam int WW = $clog2(SEARCH_WINDOW + 1);
  localparam int TW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [WW-1:0] WIN_LAST = WW'(SEARCH_WINDOW - 1);
  localparam logic [TW-1:0] TOK_LAST = TW'(LOCK_COUNT - 1);
  localparam logic [TW-1:0] TOK_MAX  = TW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_TIMEOUT);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [9:0]    prev_word;
  logic [9:0]    s1;
  logic [19:0]   win_buf;
  logic [9:0]    sym;
  logic [WW-1:0] win_cnt;
  logic [TW-1:0] tok_cnt;
  logic [LW-1:0] loss_cnt;
  logic          stale;
  logic          is_tok;
  logic          tok_ok;
  logic [1:0]    tok_val;
  logic [7:0]    q_raw;
  logic [7:0]    dec;
  logic [3:0]    off_next;

  assign win_buf  = {rx_word, prev_word};
  assign sym      = 10'(win_buf >> offset);
  assign off_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign tok_ok   = is_tok & ~stale;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_word <= '0;
      s1        <= '0;
    end else begin
      prev_word <= rx_word;
      s1        <= sym;
    end
  end

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (s1)
      TOK_00:  tok_val = 2'b00;
      TOK_01:  tok_val = 2'b01;
      TOK_10:  tok_val = 2'b10;
      TOK_11:  tok_val = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  always_comb begin
    q_raw  = s1[9] ? ~s1[7:0] : s1[7:0];
    dec    = '0;
    dec[0] = q_raw[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = s1[8] ? (q_raw[i] ^ q_raw[i-1])
                     : ~(q_raw[i] ^ q_raw[i-1]);
    end
  end

  // stale marks the one cycle where s1 still holds the old offset's symbol
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= SEARCH;
      offset   <= '0;
      win_cnt  <= '0;
      tok_cnt  <= '0;
      loss_cnt <= '0;
      stale    <= 1'b0;
      locked   <= 1'b0;
      de       <= 1'b0;
      data     <= '0;
      ctrl     <= '0;
    end else begin
      stale <= 1'b0;

      if (state == LOCKED) begin
        if (is_tok) begin
          de   <= 1'b0;
          data <= '0;
          ctrl <= tok_val;
        end else begin
          de   <= 1'b1;
          data <= dec;
        end
      end else begin
        de   <= 1'b0;
        data <= '0;
        ctrl <= '0;
      end

      unique case (state)
        SEARCH: begin
          if (tok_ok) begin
            state   <= VERIFY;
            tok_cnt <= TW'(1);
            win_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            offset  <= off_next;
            win_cnt <= '0;
            stale   <= 1'b1;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        VERIFY: begin
          if (tok_ok) begin
            if (tok_cnt >= TOK_LAST) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              loss_cnt <= '0;
            end
            if (tok_cnt != TOK_MAX) tok_cnt <= tok_cnt + 1'b1;
          end else begin
            state   <= SEARCH;
            win_cnt <= '0;
            tok_cnt <= '0;
          end
        end
        LOCKED: begin
          if (loss_cnt == LOSS_MAX) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            offset   <= off_next;
            stale    <= 1'b1;
            win_cnt  <= '0;
            tok_cnt  <= '0;
            loss_cnt <= '0;
          end else if (tok_ok) begin
            loss_cnt <= '0;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: serial bit stream source, TMDS encoder
// reference and brute-force inverse decode.
module tb_tmds_rx_decoder;

  localparam int SW = 16;
  localparam int LC = 8;
  localparam int LT = 100;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] rx_word = '0;
  logic       locked;
  logic [3:0] offset;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;

  int total = 0;
  int bad = 0;

  bit         sq[$];
  logic [9:0] fill_sym = T0;
  logic [9:0] w_d1 = '0;
  logic [9:0] w_d2 = '0;
  logic [9:0] w_d3 = '0;

  tmds_rx_decoder #(
    .SEARCH_WINDOW(SW),
    .LOCK_COUNT(LC),
    .LOSS_TIMEOUT(LT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_word(rx_word),
    .locked(locked),
    .offset(offset),
    .de(de),
    .data(data),
    .ctrl(ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) sq.push_back(s[i]);
  endtask

  task automatic tick();
    logic [9:0] w;
    if (sq.size() < 10) push_sym(fill_sym);
    for (int i = 0; i < 10; i++) w[i] = sq.pop_front();
    rx_word = w;
    @(posedge clk);
    #1;
    w_d3 = w_d2;
    w_d2 = w_d1;
    w_d1 = w;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut(input int shift);
    resetn = 1'b0;
    sq.delete();
    fill_sym = T0;
    for (int i = 0; i < shift; i++) sq.push_back(1'b0);
    ticks(3);
    resetn = 1'b1;
  endtask

  task automatic wait_lock(input int maxc, output int n);
    n = 0;
    while (!locked && n < maxc) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [9:0] enc(input logic [7:0] b,
                                     input logic q8,
                                     input logic q9);
    logic [7:0] m;
    m[0] = b[0];
    for (int i = 1; i < 8; i++)
      m[i] = q8 ? (m[i-1] ^ b[i]) : ~(m[i-1] ^ b[i]);
    return {q9, q8, q9 ? ~m : m};
  endfunction

  function automatic int tok_code(input logic [9:0] w);
    if (w == T0) return 0;
    if (w == T1) return 1;
    if (w == T2) return 2;
    if (w == T3) return 3;
    return -1;
  endfunction

  function automatic int dec_ref(input logic [9:0] w);
    for (int b = 0; b < 256; b++)
      if (enc(8'(b), w[8], w[9]) == w) return b;
    return -1;
  endfunction

  task automatic aligned_lock(input string tag);
    ticks(LC + 1);
    chk({tag, "_early"}, int'(locked), 0);
    tick();
    chk({tag, "_lock"}, int'(locked), 1);
    chk({tag, "_off"}, int'(offset), 0);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_ctrl"}, int'(ctrl), 0);
  endtask

  int last_ctrl;
  int n;

  task automatic data_step(input logic [9:0] s);
    int tc;
    push_sym(s);
    tick();
    tc = tok_code(w_d3);
    if (tc >= 0) begin
      last_ctrl = tc;
      chk("dat_de", int'(de), 0);
      chk("dat_data", int'(data), 0);
    end else begin
      chk("dat_de", int'(de), 1);
      chk("dat_data", int'(data), dec_ref(w_d3));
    end
    chk("dat_ctrl", int'(ctrl), last_ctrl);
  endtask

  initial begin
    logic [7:0] dir_b[4];
    dir_b[0] = 8'h00;
    dir_b[1] = 8'hFF;
    dir_b[2] = 8'h5A;
    dir_b[3] = 8'h10;

    reset_dut(0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_offset", int'(offset), 0);
    chk("rst_de", int'(de), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_ctrl", int'(ctrl), 0);

    aligned_lock("aln");

    last_ctrl = 0;
    for (int b = 0; b < 4; b++)
      for (int v = 0; v < 4; v++)
        data_step(enc(dir_b[b], v[0], v[1]));
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(4) == 0) begin
        case ($urandom_range(3))
          0: data_step(T0);
          1: data_step(T1);
          2: data_step(T2);
          default: data_step(T3);
        endcase
      end else begin
        data_step(enc(8'($urandom), 1'($urandom), 1'($urandom)));
      end
    end
    data_step(T0);
    data_step(T0);
    data_step(T0);
    chk("dat_locked", int'(locked), 1);

    reset_dut(0);
    for (int i = 0; i < 5; i++) push_sym(T0);
    push_sym(10'h100);
    ticks(15);
    chk("intr_early", int'(locked), 0);
    tick();
    chk("intr_lock", int'(locked), 1);
    chk("intr_off", int'(offset), 0);

    reset_dut(3);
    ticks(SW - 1);
    chk("mis_off0", int'(offset), 0);
    tick();
    chk("mis_off1", int'(offset), 1);
    ticks(SW);
    chk("mis_off2", int'(offset), 2);
    ticks(SW);
    chk("mis_off3", int'(offset), 3);
    chk("mis_unlocked", int'(locked), 0);
    wait_lock(40, n);
    chk("mis_lock", int'(locked), 1);
    chk("mis_lock_cyc", n, LC + 1);
    chk("mis_lock_off", int'(offset), 3);
    for (int i = 0; i < 6; i++) push_sym(T3);
    ticks(5);
    chk("mis_ctrl3", int'(ctrl), 3);
    chk("mis_de3", int'(de), 0);
    for (int i = 0; i < 6; i++) push_sym(T1);
    ticks(5);
    chk("mis_ctrl1", int'(ctrl), 1);

    #2;
    resetn = 1'b0;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_offset", int'(offset), 0);
    chk("arst_de", int'(de), 0);
    chk("arst_data", int'(data), 0);
    chk("arst_ctrl", int'(ctrl), 0);
    @(posedge clk);
    #1;
    reset_dut(0);
    aligned_lock("relk");

    reset_dut(9);
    wait_lock(9 * SW + LC + 10, n);
    chk("loss_lock", int'(locked), 1);
    chk("loss_lock_cyc", n, 9 * SW + LC + 1);
    chk("loss_off9", int'(offset), 9);
    fill_sym = 10'h100;
    ticks(LT - 2);
    chk("loss_hold", int'(locked), 1);
    chk("loss_de", int'(de), 1);
    chk("loss_data", int'(data), 0);
    n = 0;
    while (locked && n < 20) begin
      tick();
      n++;
    end
    chk("loss_drop", int'(locked), 0);
    chk("loss_wrap", int'(offset), 0);
    tick();
    chk("loss_gate_de", int'(de), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
